// File: rtl/sram_arb_if.sv
// Shared-SRAM arbitration bundle: CPU, CRTC DMA and aux master requests plus the muxed SRAM port.
// The arbiter connects through the slave modport; the masters and SRAM side use the master modport.
interface sram_arb_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] cpu_adr;
  logic [7:0]        cpu_din;
  logic              cpu_we;
  logic              cpu_busreq;
  logic              cpu_busack;

  logic              dma_req;
  logic [ADDR_W-1:0] dma_adr;
  logic              dma_gnt;
  logic              dma_valid;

  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_adr;
  logic [7:0]        aux_din;
  logic              aux_ack;
  logic              aux_rvalid;

  logic [ADDR_W-1:0] ram_adr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic [1:0]        owner;

  modport slave (
    input  cpu_adr, cpu_din, cpu_we, cpu_busack,
    input  dma_req, dma_adr,
    input  aux_req, aux_we, aux_adr, aux_din,
    output cpu_busreq, dma_gnt, dma_valid, aux_ack, aux_rvalid,
    output ram_adr, ram_din, ram_we, owner
  );

  modport master (
    output cpu_adr, cpu_din, cpu_we, cpu_busack,
    output dma_req, dma_adr,
    output aux_req, aux_we, aux_adr, aux_din,
    input  cpu_busreq, dma_gnt, dma_valid, aux_ack, aux_rvalid,
    input  ram_adr, ram_din, ram_we, owner
  );
endinterface

// File: rtl/sram_arb.sv
// Main-SRAM arbiter: Z80 owns the bus by default; CRTC DMA bursts and aux single accesses steal it via busreq/busack.
// Optional macro SRAM_ARB_STATS_EN adds a saturating stolen-cycle counter (stat_steal) with synchronous clear (stat_clr).
module sram_arb #(
  parameter int ADDR_W   = 16,
  parameter int HOLD_MAX = 128,
  parameter int CPU_MIN  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  sram_arb_if.slave   bus
`ifdef SRAM_ARB_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_steal
`endif
);
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int SW = $clog2(CPU_MIN + 2);

  typedef enum logic [2:0] {ST_CPU, ST_REQ, ST_DMA, ST_AUX, ST_REL} state_t;

  state_t          r_state;
  logic            r_busreq;
  logic            r_dma_valid;
  logic            r_aux_rvalid;
  logic            r_aux_gap;
  logic [HW-1:0]   r_hold;
  logic [SW-1:0]   r_slot;

  logic              w_hold_full;
  logic [HW-1:0]     w_hold_next;
  logic              w_dma_gnt;
  logic              w_aux_ack;
  logic [ADDR_W-1:0] w_ram_adr;
  logic [7:0]        w_ram_din;
  logic              w_ram_we;
  logic [1:0]        w_owner;

  // A dropped busack kills any access in the same cycle, as does an exhausted hold budget.
  assign w_hold_full = (r_hold == HW'(HOLD_MAX));
  assign w_hold_next = w_hold_full ? r_hold : r_hold + HW'(1);
  assign w_dma_gnt   = (r_state == ST_DMA) && bus.dma_req && bus.cpu_busack && !w_hold_full;
  assign w_aux_ack   = (r_state == ST_AUX) && !r_aux_gap && bus.aux_req && bus.cpu_busack && !w_hold_full;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_ram_adr = bus.cpu_adr;
    w_ram_din = bus.cpu_din;
    w_ram_we  = 1'b0;
    w_owner   = 2'd0;
    case (r_state)
      ST_CPU: w_ram_we = bus.cpu_we;
      ST_DMA: begin
        w_ram_adr = bus.dma_adr;
        w_owner   = 2'd1;
      end
      ST_AUX: begin
        w_ram_adr = bus.aux_adr;
        w_ram_din = bus.aux_din;
        w_ram_we  = w_aux_ack && bus.aux_we;
        w_owner   = 2'd2;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_CPU;
      r_busreq     <= 1'b0;
      r_dma_valid  <= 1'b0;
      r_aux_rvalid <= 1'b0;
      r_aux_gap    <= 1'b0;
      r_hold       <= '0;
      r_slot       <= '0;
    end else begin
      r_dma_valid  <= w_dma_gnt;
      r_aux_rvalid <= w_aux_ack && !bus.aux_we;
      r_aux_gap    <= 1'b0;
      case (r_state)
        ST_CPU: begin
          r_hold <= '0;
          if (r_slot != '0) begin
            r_slot <= r_slot - SW'(1);
          end else if (bus.dma_req || bus.aux_req) begin
            r_state  <= ST_REQ;
            r_busreq <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!bus.dma_req && !bus.aux_req) begin
            r_state  <= ST_REL;
            r_busreq <= 1'b0;
          end else if (bus.cpu_busack) begin
            r_state <= bus.dma_req ? ST_DMA : ST_AUX;
          end
        end
        ST_DMA: begin
          r_hold <= w_hold_next;
          if (!bus.cpu_busack || w_hold_full || (!bus.dma_req && !bus.aux_req)) begin
            r_state  <= ST_REL;
            r_busreq <= 1'b0;
          end else if (!bus.dma_req) begin
            r_state <= ST_AUX;
          end
        end
        ST_AUX: begin
          r_hold <= w_hold_next;
          // After an ack, one gap cycle lets the aux master drop aux_req before it is seen again.
          if (!bus.cpu_busack || w_hold_full) begin
            r_state  <= ST_REL;
            r_busreq <= 1'b0;
          end else if (bus.dma_req) begin
            r_state <= ST_DMA;
          end else if (w_aux_ack) begin
            r_aux_gap <= 1'b1;
          end else if (!bus.aux_req) begin
            r_state  <= ST_REL;
            r_busreq <= 1'b0;
          end
        end
        ST_REL: begin
          r_slot <= SW'(CPU_MIN);
          if (!bus.cpu_busack) r_state <= ST_CPU;
        end
        default: r_state <= ST_CPU;
      endcase
    end
  end

  assign bus.cpu_busreq = r_busreq;
  assign bus.dma_gnt    = w_dma_gnt;
  assign bus.dma_valid  = r_dma_valid;
  assign bus.aux_ack    = w_aux_ack;
  assign bus.aux_rvalid = r_aux_rvalid;
  assign bus.ram_adr    = w_ram_adr;
  assign bus.ram_din    = w_ram_din;
  assign bus.ram_we     = w_ram_we;
  assign bus.owner      = w_owner;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] r_steal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_steal <= '0;
    end else if (stat_clr) begin
      r_steal <= '0;
    end else if (r_state != ST_CPU && r_steal != 16'hFFFF) begin
      r_steal <= r_steal + 16'd1;
    end
  end

  assign stat_steal = r_steal;
`endif
endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: a 2-cycle busack CPU model, a CRTC address model and a byte SRAM model.
module tb_sram_arb;
  localparam int ADDR_W   = 16;
  localparam int HOLD_MAX = 128;
  localparam int CPU_MIN  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sram_arb_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef SRAM_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_steal;
`endif

  sram_arb #(
    .ADDR_W  (ADDR_W),
    .HOLD_MAX(HOLD_MAX),
    .CPU_MIN (CPU_MIN)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
`ifdef SRAM_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_steal(stat_steal)
`endif
  );

  logic [7:0] mem [0:65535];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_adr] <= bus.ram_din;
    ram_q <= mem[bus.ram_adr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor / environment state, written only by the monitor block below.
  logic              cpu_auto = 1'b1;
  logic              busack_man = 1'b0;
  logic              clr_req = 1'b0;
  logic [ADDR_W-1:0] adr_base = '0;
  logic              bq_d = 1'b0;
  logic              adv = 1'b0;
  logic              prev_gnt = 1'b0;
  logic              prev_rv = 1'b0;
  logic              prev_busreq = 1'b0;
  logic [3:0]        owner_mask = '0;
  int gnt_cnt = 0, valid_cnt = 0, we_cnt = 0, ack_cnt = 0, rvalid_cnt = 0;
  int valid_err = 0, rvalid_err = 0, adr_err = 0, rise_cnt = 0;
  int run = 0, max_run = 0, gap = 0, min_gap = 1000, gnt_at_ack = -1;

  // Inputs change on the falling edge; outputs are sampled 2 units later, mid-cycle.
  always @(negedge clk) begin
    if (clr_req) begin
      gnt_cnt = 0; valid_cnt = 0; we_cnt = 0; ack_cnt = 0; rvalid_cnt = 0;
      valid_err = 0; rvalid_err = 0; adr_err = 0; rise_cnt = 0;
      run = 0; max_run = 0; gap = 0; min_gap = 1000; gnt_at_ack = -1;
      owner_mask = '0;
      bus.dma_adr = adr_base;
      adv = 1'b0;
    end else if (adv) begin
      bus.dma_adr = bus.dma_adr + 1'b1;
      adv = 1'b0;
    end
    bus.cpu_busack = cpu_auto ? bq_d : busack_man;
    bq_d = bus.cpu_busreq;
    #2;
    if (bus.dma_gnt) begin
      gnt_cnt++;
      adv = 1'b1;
      run++;
      if (run > max_run) max_run = run;
      if (bus.ram_adr !== bus.dma_adr) adr_err++;
    end else begin
      run = 0;
    end
    if (bus.dma_valid) valid_cnt++;
    if (bus.dma_valid !== prev_gnt) valid_err++;
    if (bus.ram_we) we_cnt++;
    if (bus.aux_ack) begin
      ack_cnt++;
      gnt_at_ack = gnt_cnt;
    end
    if (bus.aux_rvalid) rvalid_cnt++;
    if (bus.aux_rvalid !== prev_rv) rvalid_err++;
    if (bus.cpu_busreq && !prev_busreq) begin
      if (rise_cnt > 0 && gap < min_gap) min_gap = gap;
      rise_cnt++;
    end
    if (!bus.cpu_busreq && !bus.cpu_busack) gap++;
    else gap = 0;
    owner_mask[bus.owner] = 1'b1;
    prev_gnt    = bus.dma_gnt;
    prev_rv     = bus.aux_ack & ~bus.aux_we;
    prev_busreq = bus.cpu_busreq;
  end

  task automatic clear(input logic [ADDR_W-1:0] base);
    adr_base = base;
    clr_req  = 1'b1;
    @(negedge clk); #3;
    clr_req  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    for (int i = 0; i < 300 && quiet < 8; i++) begin
      @(negedge clk); #3;
      if (!bus.cpu_busreq && !bus.cpu_busack && bus.owner == 2'd0) quiet++;
      else quiet = 0;
    end
    check(tag, quiet, 8);
  endtask

  task automatic wait_gnts(input int n);
    for (int i = 0; i < 2000 && gnt_cnt < n; i++) begin
      @(negedge clk); #3;
    end
  endtask

  task automatic wait_ack(input string tag);
    for (int i = 0; i < 100 && !bus.aux_ack; i++) begin
      @(negedge clk); #3;
    end
    check(tag, bus.aux_ack, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.cpu_adr = 16'h1234;
    bus.cpu_din = 8'h77;
    bus.cpu_we  = 1'b0;
    bus.dma_req = 1'b0;
    bus.aux_req = 1'b0;
    bus.aux_we  = 1'b0;
    bus.aux_adr = '0;
    bus.aux_din = '0;

    // Reset state
    #12;
    check("rst_busreq", bus.cpu_busreq, 1'b0);
    check("rst_gnt",    bus.dma_gnt,    1'b0);
    check("rst_valid",  bus.dma_valid,  1'b0);
    check("rst_ack",    bus.aux_ack,    1'b0);
    check("rst_rvalid", bus.aux_rvalid, 1'b0);
    check("rst_we",     bus.ram_we,     1'b0);
    check("rst_owner",  bus.owner,      2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_idle("idle0");

    // 120-beat DMA burst
    clear(16'h4000);
    @(negedge clk);
    bus.dma_req = 1'b1;
    wait_gnts(120);
    @(negedge clk);
    bus.dma_req = 1'b0;
    wait_idle("idle1");
    check("b1_gnt",      gnt_cnt,     120);
    check("b1_valid",    valid_cnt,   120);
    check("b1_valid_dl", valid_err,   0);
    check("b1_we",       we_cnt,      0);
    check("b1_adr",      adr_err,     0);
    check("b1_adr_end",  bus.dma_adr, 16'h4000 + 16'd120);
    check("b1_busreq",   rise_cnt,    1);
    check("b1_owner",    owner_mask,  4'b0011);

    // Aux write then read-back of 0x8123
    clear(16'h0000);
    @(negedge clk);
    bus.aux_we  = 1'b1;
    bus.aux_adr = 16'h8123;
    bus.aux_din = 8'h5A;
    bus.aux_req = 1'b1;
    wait_ack("aw_ack_seen");
    check("aw_adr", bus.ram_adr, 16'h8123);
    check("aw_din", bus.ram_din, 8'h5A);
    check("aw_we",  bus.ram_we,  1'b1);
    @(negedge clk);
    bus.aux_req = 1'b0;
    wait_idle("idle2");
    check("aw_ack_cnt", ack_cnt, 1);
    check("aw_we_cnt",  we_cnt,  1);
    check("aw_mem",     mem[16'h8123], 8'h5A);
    @(negedge clk);
    bus.aux_we  = 1'b0;
    bus.aux_req = 1'b1;
    wait_ack("ar_ack_seen");
    @(negedge clk);
    bus.aux_req = 1'b0;
    for (int i = 0; i < 10 && !bus.aux_rvalid; i++) begin
      @(negedge clk); #3;
    end
    check("ar_rvalid", bus.aux_rvalid, 1'b1);
    check("ar_q",      ram_q,          8'h5A);
    wait_idle("idle3");
    check("ar_rv_cnt", rvalid_cnt, 1);
    check("ar_rv_dl",  rvalid_err, 0);
    check("ar_we_cnt", we_cnt,     1);

    // Simultaneous DMA and aux: DMA first, aux after the burst, one busreq
    clear(16'h5000);
    @(negedge clk);
    bus.aux_we  = 1'b1;
    bus.aux_adr = 16'h0100;
    bus.aux_din = 8'hC3;
    bus.aux_req = 1'b1;
    bus.dma_req = 1'b1;
    wait_gnts(8);
    @(negedge clk);
    bus.dma_req = 1'b0;
    wait_ack("sim_ack_seen");
    @(negedge clk);
    bus.aux_req = 1'b0;
    wait_idle("idle4");
    check("sim_gnt",     gnt_cnt,    8);
    check("sim_gnt_ack", gnt_at_ack, 8);
    check("sim_ack",     ack_cnt,    1);
    check("sim_busreq",  rise_cnt,   1);
    check("sim_mem",     mem[16'h0100], 8'hC3);
    check("sim_owner",   owner_mask, 4'b0111);

    // HOLD_MAX: 300 beats split 128 + 128 + 44 with forced CPU slots
    clear(16'h1000);
    @(negedge clk);
    bus.dma_req = 1'b1;
    wait_gnts(300);
    @(negedge clk);
    bus.dma_req = 1'b0;
    wait_idle("idle5");
    check("hm_gnt",     gnt_cnt,  300);
    check("hm_run",     max_run,  HOLD_MAX);
    check("hm_busreq",  rise_cnt, 3);
    check("hm_cpu_gap", min_gap >= CPU_MIN, 1'b1);
    check("hm_adr",     adr_err,  0);
    check("hm_valid",   valid_err, 0);
    check("hm_adr_end", bus.dma_adr, 16'h1000 + 16'd300);

    // busack drops mid-burst (protocol error)
    clear(16'h3000);
    cpu_auto   = 1'b0;
    busack_man = 1'b0;
    @(negedge clk);
    bus.dma_req = 1'b1;
    for (int i = 0; i < 20 && !bus.cpu_busreq; i++) begin
      @(negedge clk); #3;
    end
    busack_man = 1'b1;
    wait_gnts(5);
    busack_man = 1'b0;
    @(negedge clk); #3;
    check("ad_gnt", bus.dma_gnt, 1'b0);
    check("ad_we",  bus.ram_we,  1'b0);
    @(negedge clk);
    bus.dma_req = 1'b0;
    #3;
    check("ad_busreq", bus.cpu_busreq, 1'b0);
    check("ad_owner",  bus.owner,      2'd0);
    wait_idle("idle6");
    check("ad_gnt_cnt", gnt_cnt,   5);
    check("ad_valid",   valid_cnt, 5);
    cpu_auto = 1'b1;
    wait_idle("idle7");

`ifdef SRAM_ARB_STATS_EN
    // Stolen-cycle counter: REQ 2 + DMA 11 + REL 2 = 15
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    clear(16'h2000);
    @(negedge clk);
    bus.dma_req = 1'b1;
    wait_gnts(10);
    @(negedge clk);
    bus.dma_req = 1'b0;
    wait_idle("idle8");
    check("st_gnt",   gnt_cnt,    10);
    check("st_steal", stat_steal, 16'd15);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #3;
    check("st_clr", stat_steal, 16'd0);
`endif

    // Asynchronous reset mid-burst
    clear(16'h6000);
    @(negedge clk);
    bus.dma_req = 1'b1;
    wait_gnts(3);
    #1;
    reset_n = 1'b0;
    #1;
    check("mr_busreq", bus.cpu_busreq, 1'b0);
    check("mr_gnt",    bus.dma_gnt,    1'b0);
    check("mr_valid",  bus.dma_valid,  1'b0);
    check("mr_ack",    bus.aux_ack,    1'b0);
    check("mr_rvalid", bus.aux_rvalid, 1'b0);
    check("mr_we",     bus.ram_we,     1'b0);
    check("mr_owner",  bus.owner,      2'd0);
    bus.dma_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_idle("idle9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
